abc_window_feeder: RTL and testbench
====================================

ABC_WINDOW_FEEDER -- requirements
Module: abc_window_feeder

Interface
REQ-001 The block SHALL have a parameter CNT_W, default 8, giving the width of the match counter.
REQ-002 The block SHALL have a parameter PATTERN, default 3'b110, giving the {a,b,c} value that counts as a match.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset.
REQ-004 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-006 The block SHALL have port bit_in, input, 1 bit, the serial data bit.
REQ-007 The block SHALL have port bit_valid, input, 1 bit, which qualifies bit_in.
REQ-008 The block SHALL have port bit_ready, output, 1 bit, which indicates the block accepts bit_in in this cycle.
REQ-009 The block SHALL have port clear, input, 1 bit, a synchronous flush of the window and the counter.
REQ-010 The block SHALL have ports a, b and c, outputs, 1 bit each, which drive the downstream 3-input decoder; a is the oldest bit and c the newest.
REQ-011 The block SHALL have port win_valid, output, 1 bit, which indicates that a, b and c hold 3 accepted bits.
REQ-012 The block SHALL have port match, output, 1 bit, asserted when win_valid is high and {a,b,c}==PATTERN.
REQ-013 The block SHALL have port match_count, output, CNT_W bits, the saturating count of matching windows.

Function
REQ-014 A bit SHALL be accepted on a rising clk edge exactly when bit_valid and bit_ready are both 1.
REQ-015 bit_ready SHALL equal !clear, SHALL be combinational, and SHALL be low while rst_n is low.
REQ-016 On each accepted bit, the window SHALL shift in the same edge: {a,b,c} <= {b,c,bit_in}.
REQ-017 Windows SHALL overlap: every accepted bit after the window is filled produces a new window.
REQ-018 The fill state machine SHALL have states EMPTY, FILL1, FILL2 and FULL.
REQ-019 State transitions: EMPTY->FILL1->FILL2->FULL, one step per accepted bit.
REQ-020 FULL SHALL stay FULL on accepted bits.
REQ-021 Any state SHALL go to EMPTY on clear.
REQ-022 No state change SHALL occur without an accepted bit or a clear.
REQ-023 win_valid SHALL be registered and SHALL be 1 exactly when the state is FULL.
REQ-024 win_valid SHALL rise on the edge that accepts the 3rd bit, so latency from 3rd accept to win_valid is 0 cycles after that edge.
REQ-025 match SHALL be combinational from the registered window and state, with no extra latency.
REQ-026 match_count SHALL increment on the edge where an accepted bit moves the machine into FULL, or keeps it in FULL, with a new window equal to PATTERN.
REQ-027 A window held across idle cycles SHALL be counted only once.
REQ-028 match_count SHALL saturate at 2^CNT_W-1, with no wrap to 0.
REQ-029 Windows SHALL NOT count while in EMPTY, FILL1 or FILL2, even when the partial bits equal PATTERN.
REQ-030 Clear SHALL take priority over a simultaneous bit_valid: the bit is not accepted (bit_ready=0).
REQ-031 On clear, the next edge SHALL set {a,b,c}=3'b000, the state to EMPTY, win_valid=0 and match_count=0.
REQ-032 Holding clear high for several cycles SHALL keep the block in its cleared condition.

Reset
REQ-033 While rst_n is low, outputs SHALL be asynchronously forced to a=b=c=0, win_valid=0, match=0, match_count=0 and state EMPTY.
REQ-034 Reset asserted mid-fill or mid-stream SHALL discard the partial window.
REQ-035 After rst_n deasserts, the first accepted bit SHALL enter FILL1.
REQ-036 bit_ready SHALL be 0 while in reset.

Structure
REQ-037 A shared package feeder_pkg SHALL hold the fill state enumeration (EMPTY, FILL1, FILL2, FULL) and the default PATTERN constant.
REQ-038 The saturating counter SHALL be one sub-module named sat_counter, with ports clk, rst_n, clr, inc and count, and parameter width CNT_W.
REQ-039 The window register, the fill state machine and the handshake logic SHALL stay in abc_window_feeder.

Verification
REQ-040 Scenario: after reset, stream bits 1,1,0 with bit_valid held high -> win_valid rises after the 3rd edge, {a,b,c}=110, match=1, match_count=1.
REQ-041 Scenario: stream 1,1,0,1,1,0 contiguously -> match_count=2, match high on the 3rd and 6th windows only, windows 101 and 011 not counted.
REQ-042 Scenario: send 1,1 then hold bit_valid=0 for 5 cycles, then send 0 -> state stays FILL2 during the gap, match_count becomes 1 only after the 0 is accepted.
REQ-043 Scenario: raise clear together with bit_valid=1 while in FULL -> bit_ready=0, next edge gives {a,b,c}=000, win_valid=0, match_count=0.
REQ-044 Scenario: with CNT_W=2, send 4 matching windows -> match_count reads 1,2,3,3.
REQ-045 Scenario: assert rst_n low asynchronously between edges after 2 accepted bits -> outputs are 0 immediately, and after release the sequence 1,1,0 is needed again for win_valid.

Source files
------------

// File: rtl/feeder_pkg.sv
// Shared types for the abc window feeder: fill-state encoding and default match pattern.
package feeder_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL1 = 2'd1,
        FILL2 = 2'd2,
        FULL  = 2'd3
    } fill_state_t;

    localparam logic [2:0] DEFAULT_PATTERN = 3'b110;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; count updates on the edge after inc.
// Clear wins over inc; the count holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/abc_window_feeder.sv
// Serial-to-3-bit sliding window feeding a decoder; window, win_valid and count update on the accepting edge.
// bit_ready is simply !clear (and low in reset); clear flushes window, fill state and match count.
module abc_window_feeder
    import feeder_pkg::*;
#(
    parameter int         CNT_W   = 8,
    parameter logic [2:0] PATTERN = DEFAULT_PATTERN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    input  logic             clear,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             win_valid,
    output logic             match,
    output logic [CNT_W-1:0] match_count
);

    fill_state_t r_state;
    fill_state_t w_state_nxt;
    logic [2:0]  r_win;
    logic        r_win_valid;
    logic        w_accept;
    logic [2:0]  w_new_win;
    logic        w_count_inc;

    assign bit_ready = rst_n & ~clear;
    assign w_accept  = bit_valid & bit_ready;
    assign w_new_win = {r_win[1:0], bit_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Only a window formed while entering or staying in FULL is countable.
    always_comb begin
        w_state_nxt = r_state;
        w_count_inc = 1'b0;
        if (clear) begin
            w_state_nxt = EMPTY;
        end else if (w_accept) begin
            case (r_state)
                EMPTY:   w_state_nxt = FILL1;
                FILL1:   w_state_nxt = FILL2;
                FILL2:   w_state_nxt = FULL;
                default: w_state_nxt = FULL;
            endcase
            w_count_inc = ((r_state == FILL2) || (r_state == FULL)) && (w_new_win == PATTERN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win       <= 3'b000;
            r_win_valid <= 1'b0;
        end else begin
            if (clear) begin
                r_win <= 3'b000;
            end else if (w_accept) begin
                r_win <= w_new_win;
            end
            r_win_valid <= (w_state_nxt == FULL);
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (w_count_inc),
        .count (match_count)
    );

    assign a         = r_win[2];
    assign b         = r_win[1];
    assign c         = r_win[0];
    assign win_valid = r_win_valid;
    assign match     = r_win_valid && (r_win == PATTERN);

endmodule

// File: tb/tb_abc_window_feeder.sv
// Scoreboard bench for abc_window_feeder: directed streams push expected windows, a monitor checks each accept.
module tb_abc_window_feeder;

    typedef struct {
        logic [2:0] abc;
        logic       wv;
        logic       m;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       bit_in;
    logic       bit_valid;
    logic       clear;
    logic       bit_ready, a, b, c, win_valid, match;
    logic [7:0] match_count;
    logic       bit_ready2, a2, b2, c2, win_valid2, match2;
    logic [1:0] match_count2;
    logic       bit_ready3, a3, b3, c3, win_valid3, match3;
    logic [7:0] match_count3;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    abc_window_feeder #(.CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .clear(clear), .a(a), .b(b), .c(c), .win_valid(win_valid), .match(match),
        .match_count(match_count)
    );

    abc_window_feeder #(.CNT_W(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready2),
        .clear(clear), .a(a2), .b(b2), .c(c2), .win_valid(win_valid2), .match(match2),
        .match_count(match_count2)
    );

    // Pattern 001 appears as a partial window while filling and must never match or count there.
    abc_window_feeder #(.CNT_W(8), .PATTERN(3'b001)) u_dut_pat (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready3),
        .clear(clear), .a(a3), .b(b3), .c(c3), .win_valid(win_valid3), .match(match3),
        .match_count(match_count3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic bv, input logic [2:0] abc, input logic wv, input logic m,
                        input logic [7:0] cnt);
        exp_t e;
        @(negedge clk);
        bit_in    = bv;
        bit_valid = 1'b1;
        e.abc  = abc;
        e.wv   = wv;
        e.m    = m;
        e.cnt  = cnt;
        e.cnt2 = (cnt > 8'd3) ? 2'd3 : cnt[1:0];
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bit_valid = 1'b0;
        for (int i = 1; i < n; i++) @(negedge clk);
    endtask

    task automatic chk_cleared(input string name);
        chk({name, "_abc"},   32'({a, b, c}), 32'd0);
        chk({name, "_wv"},    32'(win_valid), 32'd0);
        chk({name, "_match"}, 32'(match), 32'd0);
        chk({name, "_cnt"},   32'(match_count), 32'd0);
        chk({name, "_cnt2"},  32'(match_count2), 32'd0);
    endtask

    // Clear raised together with a valid bit; the bit must be refused.
    task automatic do_clear(input int hold);
        @(negedge clk);
        clear     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        #1 chk("ready_during_clear", 32'(bit_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1 chk_cleared("cleared");
        end
        clear     = 1'b0;
        bit_valid = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        logic acc;
        forever begin
            @(posedge clk);
            acc = bit_valid & bit_ready;
            #1;
            if (acc) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_accept: accept with empty scoreboard at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("win_abc",   32'({a, b, c}), 32'(e.abc));
                    chk("win_valid", 32'(win_valid), 32'(e.wv));
                    chk("win_match", 32'(match), 32'(e.m));
                    chk("win_count", 32'(match_count), 32'(e.cnt));
                    chk("win_count_sat", 32'(match_count2), 32'(e.cnt2));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b1;
        clear     = 1'b0;
        #3;
        chk("reset_ready", 32'(bit_ready), 32'd0);
        chk_cleared("reset");
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        bit_valid = 1'b0;
        #1 chk("ready_after_reset", 32'(bit_ready), 32'd1);

        // First window 110 after reset; FILL1 window 001 must not match in the 001-pattern instance.
        send(1'b1, 3'b001, 1'b0, 1'b0, 8'd0);
        idle(1);
        #1 chk("partial_no_match", 32'(match3), 32'd0);
        send(1'b1, 3'b011, 1'b0, 1'b0, 8'd0);
        send(1'b0, 3'b110, 1'b1, 1'b1, 8'd1);
        idle(3);
        #1;
        chk("held_match", 32'(match), 32'd1);
        chk("held_count_once", 32'(match_count), 32'd1);
        chk("partial_no_count", 32'(match_count3), 32'd0);

        // Clear from FULL with bit_valid high, held for several cycles.
        do_clear(3);

        // Overlapping windows: only the two 110 windows count.
        send(1'b1, 3'b001, 1'b0, 1'b0, 8'd0);
        send(1'b1, 3'b011, 1'b0, 1'b0, 8'd0);
        send(1'b0, 3'b110, 1'b1, 1'b1, 8'd1);
        send(1'b1, 3'b101, 1'b1, 1'b0, 8'd1);
        send(1'b1, 3'b011, 1'b1, 1'b0, 8'd1);
        send(1'b0, 3'b110, 1'b1, 1'b1, 8'd2);
        idle(1);

        // Gap while in FILL2 leaves the window and state untouched.
        do_clear(1);
        send(1'b1, 3'b001, 1'b0, 1'b0, 8'd0);
        send(1'b1, 3'b011, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bit_valid = 1'b0;
            #1;
            chk("gap_abc", 32'({a, b, c}), 32'd3);
            chk("gap_wv", 32'(win_valid), 32'd0);
            chk("gap_cnt", 32'(match_count), 32'd0);
        end
        send(1'b0, 3'b110, 1'b1, 1'b1, 8'd1);
        idle(1);

        // Four matching windows: 8-bit count reaches 4, 2-bit count sticks at 3.
        do_clear(1);
        for (int k = 0; k < 4; k++) begin
            send(1'b1, (k == 0) ? 3'b001 : 3'b101, (k != 0), 1'b0, 8'(k));
            send(1'b1, 3'b011, (k != 0), 1'b0, 8'(k));
            send(1'b0, 3'b110, 1'b1, 1'b1, 8'(k + 1));
        end
        idle(1);

        // Asynchronous reset mid-fill discards the partial window.
        do_clear(1);
        send(1'b1, 3'b001, 1'b0, 1'b0, 8'd0);
        send(1'b1, 3'b011, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        bit_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", 32'(bit_ready), 32'd0);
        chk_cleared("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b1, 3'b001, 1'b0, 1'b0, 8'd0);
        send(1'b1, 3'b011, 1'b0, 1'b0, 8'd0);
        send(1'b0, 3'b110, 1'b1, 1'b1, 8'd1);
        idle(3);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
